// File: rtl/unidade_controle_mc.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_mc
// Description : Multicycle RV32I control FSM with instruction/data memory
//               ready handshakes and branch decode from ALU flags.
//               Define ILLEGAL_TRAP_EN to trap illegal opcodes (adds
//               illegal_instr); otherwise they retire as NOPs.
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_mc #(
    parameter int ALU_CMD_W = 4,
    parameter int FLAG_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic [FLAG_W-1:0]    alu_flags,
    input  logic                 i_mem_ready,
    input  logic                 d_mem_ready,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic                 d_mem_re,
    output logic                 d_mem_we,
    output logic                 rf_we,
    output logic [ALU_CMD_W-1:0] alu_cmd,
    output logic [1:0]           alu_src_a,
    output logic                 alu_src_b,
    output logic [1:0]           pc_src,
    output logic [1:0]           rf_src,
`ifdef ILLEGAL_TRAP_EN
    output logic                 illegal_instr,
`endif
    output logic [3:0]           state_o
);

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;

    localparam logic [ALU_CMD_W-1:0] c_ALU_ADD    = ALU_CMD_W'(0);
    localparam logic [ALU_CMD_W-1:0] c_ALU_SUB    = ALU_CMD_W'(1);
    localparam logic [ALU_CMD_W-1:0] c_ALU_PASS_B = ALU_CMD_W'(2);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EX_ALU    = 4'd2,
        S_EX_ALUI   = 4'd3,
        S_EX_ADDR   = 4'd4,
        S_MEM_RD    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_EX_BRANCH = 4'd7,
        S_EX_JAL    = 4'd8,
        S_EX_JALR   = 4'd9,
        S_EX_UPPER  = 4'd10,
        S_WRITEBACK = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_from_mem;
    logic   w_taken;

    wire w_z = alu_flags[3];
    wire w_n = alu_flags[2];
    wire w_c = alu_flags[1];
    wire w_v = alu_flags[0];

    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = w_z;
            3'b001:  w_taken = !w_z;
            3'b100:  w_taken = w_n ^ w_v;
            3'b101:  w_taken = !(w_n ^ w_v);
            3'b110:  w_taken = !w_c;
            3'b111:  w_taken = w_c;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:     w_next_state = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    c_OP_R:                  w_next_state = S_EX_ALU;
                    c_OP_I:                  w_next_state = S_EX_ALUI;
                    c_OP_LOAD, c_OP_STORE:   w_next_state = S_EX_ADDR;
                    c_OP_BR:                 w_next_state = S_EX_BRANCH;
                    c_OP_JAL:                w_next_state = S_EX_JAL;
                    c_OP_JALR:               w_next_state = S_EX_JALR;
                    c_OP_LUI, c_OP_AUIPC:    w_next_state = S_EX_UPPER;
`ifdef ILLEGAL_TRAP_EN
                    default:                 w_next_state = S_TRAP;
`else
                    default:                 w_next_state = S_FETCH;
`endif
                endcase
            end
            S_EX_ALU:    w_next_state = S_WRITEBACK;
            S_EX_ALUI:   w_next_state = S_WRITEBACK;
            S_EX_ADDR:   w_next_state = (opcode == c_OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    w_next_state = d_mem_ready ? S_WRITEBACK : S_MEM_RD;
            S_MEM_WR:    w_next_state = d_mem_ready ? S_FETCH : S_MEM_WR;
            S_EX_BRANCH: w_next_state = S_FETCH;
            S_EX_JAL:    w_next_state = S_FETCH;
            S_EX_JALR:   w_next_state = S_FETCH;
            S_EX_UPPER:  w_next_state = S_WRITEBACK;
            S_WRITEBACK: w_next_state = S_FETCH;
            S_TRAP:      w_next_state = S_TRAP;
            default:     w_next_state = S_FETCH;
        endcase
    end

    // r_from_mem steers WRITEBACK to memory data for the load that just completed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_from_mem <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_MEM_RD && d_mem_ready) begin
                r_from_mem <= 1'b1;
            end else if (r_state == S_FETCH) begin
                r_from_mem <= 1'b0;
            end
        end
    end

    // Outputs follow the current state; reset suppresses every strobe and select
    always_comb begin
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        d_mem_re  = 1'b0;
        d_mem_we  = 1'b0;
        rf_we     = 1'b0;
        alu_cmd   = c_ALU_ADD;
        alu_src_a = 2'd0;
        alu_src_b = 1'b0;
        pc_src    = 2'd0;
        rf_src    = 2'd0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    ir_we = i_mem_ready;
                    pc_we = i_mem_ready;
                end
                S_EX_ALU: begin
                    alu_cmd = funct7_5 ? c_ALU_SUB : c_ALU_ADD;
                end
                S_EX_ALUI, S_EX_ADDR: begin
                    alu_src_b = 1'b1;
                end
                S_MEM_RD: begin
                    d_mem_re = 1'b1;
                    rf_src   = 2'd1;
                end
                S_MEM_WR: begin
                    d_mem_we = 1'b1;
                end
                S_EX_BRANCH: begin
                    alu_cmd = c_ALU_SUB;
                    pc_we   = w_taken;
                    pc_src  = w_taken ? 2'd1 : 2'd0;
                end
                S_EX_JAL: begin
                    pc_we  = 1'b1;
                    pc_src = 2'd1;
                    rf_we  = 1'b1;
                    rf_src = 2'd2;
                end
                S_EX_JALR: begin
                    alu_src_b = 1'b1;
                    pc_we     = 1'b1;
                    pc_src    = 2'd2;
                    rf_we     = 1'b1;
                    rf_src    = 2'd2;
                end
                S_EX_UPPER: begin
                    alu_src_b = 1'b1;
                    if (opcode == c_OP_LUI) begin
                        alu_src_a = 2'd2;
                        alu_cmd   = c_ALU_PASS_B;
                    end else begin
                        alu_src_a = 2'd1;
                    end
                end
                S_WRITEBACK: begin
                    rf_we  = 1'b1;
                    rf_src = r_from_mem ? 2'd1 : 2'd0;
                end
                default: ;
            endcase
        end
    end

    assign state_o = r_state;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = (r_state == S_TRAP);
`endif

endmodule
`default_nettype wire
